// File: rtl/sseg_scan.sv
// Multiplexed seven-segment scanner: frame-synchronous shadowing of the display
// data, one dead cycle per digit slot, PWM brightness and leading-zero blanking.
module sseg_scan #(
  parameter int N   = 16,
  parameter int DIV = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in,
  input  logic [N/4-1:0]   dp,
  input  logic             lzs,
  input  logic [3:0]       bright,
  output logic [7:0]       c,
  output logic [N/4-1:0]   an
);

  localparam int NDIGITS = N / 4;
  localparam int IW      = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int PW      = $clog2(DIV);

  logic [PW-1:0]      pre_q, pre_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [3:0]         pwm_q, pwm_d;
  logic [N-1:0]       sh_in_q, sh_in_d;
  logic [NDIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [7:0]         c_q, c_d;
  logic [NDIGITS-1:0] an_q, an_d;

  logic               slot_end;
  logic               pwm_en;
  logic [N-1:0]       upper;
  logic [6:0]         seg;

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0:    hex_seg = 7'h40;
      4'h1:    hex_seg = 7'h79;
      4'h2:    hex_seg = 7'h24;
      4'h3:    hex_seg = 7'h30;
      4'h4:    hex_seg = 7'h19;
      4'h5:    hex_seg = 7'h12;
      4'h6:    hex_seg = 7'h02;
      4'h7:    hex_seg = 7'h78;
      4'h8:    hex_seg = 7'h00;
      4'h9:    hex_seg = 7'h10;
      4'hA:    hex_seg = 7'h08;
      4'hB:    hex_seg = 7'h03;
      4'hC:    hex_seg = 7'h46;
      4'hD:    hex_seg = 7'h21;
      4'hE:    hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    pre_d    = pre_q + 1'b1;
    idx_d    = idx_q;
    pwm_d    = pwm_q + 1'b1;
    sh_in_d  = sh_in_q;
    sh_dp_d  = sh_dp_q;
    slot_end = (pre_q == PW'(DIV - 1));

    if (slot_end) begin
      pre_d = '0;
      if (idx_q == IW'(NDIGITS - 1)) begin
        idx_d   = '0;
        sh_in_d = in;
        sh_dp_d = dp;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // Blank a digit when it and every digit to its left are zero; digit 0 always shows.
    upper = sh_in_q >> {idx_q, 2'b00};
    seg   = hex_seg(upper[3:0]);
    if (lzs && (idx_q != '0) && (upper == '0)) begin
      seg = 7'h7F;
    end
    c_d = {~sh_dp_q[idx_q], seg};

    pwm_en = (bright == 4'hF) || (pwm_q < bright);
    an_d   = '1;
    if ((pre_q != '0) && pwm_en) begin
      an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      pre_q   <= '0;
      idx_q   <= '0;
      pwm_q   <= '0;
      sh_in_q <= '0;
      sh_dp_q <= '0;
      c_q     <= 8'hFF;
      an_q    <= '1;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      pwm_q   <= pwm_d;
      sh_in_q <= sh_in_d;
      sh_dp_q <= sh_dp_d;
      c_q     <= c_d;
      an_q    <= an_d;
    end
  end

  assign c  = c_q;
  assign an = an_q;

endmodule

// File: tb/tb_sseg_scan.sv
// Scoreboard bench for sseg_scan: two instances (DIV=4 and DIV=64) share stimulus and are
// checked against a cycle-count model that derives slot, digit and frame by arithmetic.
module tb_sseg_scan;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] c;
  } exp_t;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_v;
  logic [3:0]  dp_v;
  logic        lzs;
  logic [3:0]  bright;
  logic [7:0]  c4, c64;
  logic [3:0]  an4, an64;

  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "reset";

  exp_t  q4[$];
  exp_t  q64[$];
  int    n4 = 0, n64 = 0;
  logic [15:0] sh4 = '0, sh64 = '0;
  logic [3:0]  dsh4 = '0, dsh64 = '0;

  sseg_scan #(.N(16), .DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .in(in_v), .dp(dp_v), .lzs(lzs), .bright(bright),
    .c(c4), .an(an4)
  );

  sseg_scan #(.N(16), .DIV(64)) u_dut64 (
    .clk(clk), .rst(rst), .in(in_v), .dp(dp_v), .lzs(lzs), .bright(bright),
    .c(c64), .an(an64)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (an,c)", name, act, exp);
    end
  endtask

  // Expected output registered at the end of cycle n (n cycles since reset released).
  function automatic exp_t expect_out(input int div, input int n, input logic [15:0] sh,
                                      input logic [3:0] dsh, input logic lz, input logic [3:0] br);
    exp_t        e;
    int          pre, idx, pwm;
    logic [15:0] upper;
    logic [6:0]  seg;
    pre   = n % div;
    idx   = (n / div) % 4;
    pwm   = n % 16;
    upper = sh >> (4 * idx);
    seg   = SEG_TAB[upper[3:0]];
    if (lz && idx > 0 && upper == 16'h0) seg = 7'h7F;
    e.c  = {~dsh[idx], seg};
    e.an = 4'hF;
    if (pre != 0 && (br == 4'hF || pwm < int'(br))) e.an[idx] = 1'b0;
    return e;
  endfunction

  // Reference model: samples inputs at each rising edge, pushes the expected next output.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      q4.push_back('{an: 4'hF, c: 8'hFF});
      q64.push_back('{an: 4'hF, c: 8'hFF});
      n4 = 0; n64 = 0; sh4 = '0; sh64 = '0; dsh4 = '0; dsh64 = '0;
    end else begin
      q4.push_back(expect_out(4, n4, sh4, dsh4, lzs, bright));
      q64.push_back(expect_out(64, n64, sh64, dsh64, lzs, bright));
      if ((n4 + 1) % 16 == 0)  begin sh4 = in_v;  dsh4 = dp_v;  end
      if ((n64 + 1) % 256 == 0) begin sh64 = in_v; dsh64 = dp_v; end
      n4++;
      n64++;
    end
  end

  // Monitor: every cycle presents an output; compare away from the active edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q4.size() > 0) begin
      e = q4.pop_front();
      check({"div4 ", phase}, {an4, c4}, {e.an, e.c});
      check({"div4 one_anode ", phase}, {11'd0, $countones(~an4) <= 1}, 12'd1);
    end
    if (q64.size() > 0) begin
      e = q64.pop_front();
      check({"div64 ", phase}, {an64, c64}, {e.an, e.c});
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int guard;
    rst = 1'b1; in_v = 16'hFFFF; dp_v = 4'h0; lzs = 1'b0; bright = 4'hF;
    cycles(3);

    phase = "scan_1234";
    rst = 1'b0; in_v = 16'h1234;
    cycles(16 * 3 + 6);
    phase = "midframe_5678";
    in_v = 16'h5678;
    cycles(40);

    phase = "lzs_0050";
    in_v = 16'h0050; lzs = 1'b1; dp_v = 4'b0100;
    cycles(40);
    phase = "lzs_0000";
    in_v = 16'h0000;
    cycles(40);

    lzs = 1'b0; in_v = 16'hA5C3; dp_v = 4'b1001;
    phase = "bright0";  bright = 4'h0; cycles(300);
    phase = "bright8";  bright = 4'h8; cycles(300);
    phase = "bright15"; bright = 4'hF; cycles(300);

    phase = "midslot_reset";
    guard = 0;
    while (!(((n4 / 4) % 4 == 2) && (n4 % 4 == 1)) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("midslot_wait", {11'd0, guard < 100}, 12'd1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(40);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        in_v = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      if ($urandom_range(0, 15) == 0) dp_v = 4'($urandom);
      if ($urandom_range(0, 31) == 0) lzs = 1'($urandom);
      if ($urandom_range(0, 19) == 0) bright = 4'($urandom);
      rst = ($urandom_range(0, 255) == 0);
      cycles(1);
    end
    rst = 1'b0;
    cycles(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sseg_scan.md
SSEG_SCAN -- requirements
Module: sseg_scan

Interface
REQ-001 Parameter N, default 16: display data width in bits; NDIGITS = N/4; N SHALL be a multiple of 4 in 4..32.
REQ-002 Parameter DIV, default 10000: clocks per digit slot (1 kHz slot rate at 10 MHz); DIV SHALL be >= 2.
REQ-003 clk  input  1  system clock (10 MHz DCM output); all logic SHALL be clocked on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in  input  N  hex data; nibble i (in[4i+3:4i]) drives digit i; digit 0 is rightmost.
REQ-006 dp  input  NDIGITS  decimal point per digit, 1 = lit.
REQ-007 lzs  input  1  leading-zero suppression enable.
REQ-008 bright  input  4  brightness, 0 = dark, 15 = full.
REQ-009 c  output  8  cathodes, active low; c[6:0] = segments g..a (c[0] = a), c[7] = dp; registered.
REQ-010 an  output  NDIGITS  anodes, active low, at most one bit low at any time; registered.

Function
REQ-011 Prescaler pre SHALL count 0..DIV-1 every cycle and wrap to 0.
REQ-012 When pre == DIV-1, digit index idx SHALL advance by 1, wrapping from NDIGITS-1 to 0.
REQ-013 When pre == DIV-1 and idx == NDIGITS-1 (frame boundary), shadow registers SHALL capture in and dp; display SHALL use only shadow values, so mid-frame input changes never tear a frame.
REQ-014 A free-running 4-bit counter pwm SHALL increment every cycle and wrap 15 -> 0.
REQ-015 PWM enable SHALL be (bright == 15) or (pwm < bright); bright is sampled live, not shadowed.
REQ-016 Outputs SHALL be registered: values at cycle t+1 are a function of state (pre, idx, pwm, shadow) at cycle t.
REQ-017 an SHALL be all ones when pre == 0 (one dead cycle per slot against ghosting) or PWM enable is 0; otherwise an[idx] = 0 and all other bits = 1.
REQ-018 c[6:0] SHALL decode the shadow nibble of digit idx, active low, hex 0..F -> 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
REQ-019 c[7] SHALL equal the inverse of the shadow dp bit for digit idx.
REQ-020 With lzs = 1, digit i (i >= 1) SHALL be suppressed when all shadow nibbles i..NDIGITS-1 are zero; a suppressed digit SHALL output c[6:0] = 7F with dp and an unchanged; digit 0 SHALL never be suppressed.
REQ-021 c SHALL also follow REQ-018..020 when an is all ones; c is don't-care to the panel but SHALL be deterministic for verification.

Reset
REQ-022 While rst = 1: pre, idx, and pwm SHALL be 0; shadow in and dp SHALL be 0; an SHALL be all ones; c SHALL be 8'hFF.
REQ-023 rst SHALL take priority over all other activity, including mid-slot and at a frame boundary. The first cycle after rst falls SHALL still show an all ones and c = FF. Scanning SHALL then restart at digit 0, and the first frame SHALL display zeros.

Verification (N=16, DIV=4 unless stated)
REQ-024 Hold rst = 1 for 3 cycles with in = FFFF -> an = F and c = FF throughout and on the cycle after release.
REQ-025 Release reset with in = 1234, dp = 0, bright = 15, lzs = 0:
- after the first frame boundary, each 4-cycle slot SHALL show 1 dead cycle (an = F) then 3 cycles of the digit;
- the sequence SHALL be an = E/c = 99, an = D/c = B0, an = B/c = A4, an = 7/c = F9, repeating.
REQ-026 Change in from 1234 to 5678 mid-frame -> the remaining slots of that frame SHALL still show 1234 patterns; 5678 SHALL appear from digit 0 of the next frame (c = 80).
REQ-027 Set in = 0050, lzs = 1, dp = 4'b0100:
- digit 3 SHALL show c = FF;
- digit 2 SHALL show c = 7F;
- digit 1 SHALL show c = 92;
- digit 0 SHALL show c = C0.
With in = 0000, only digit 0 SHALL show C0.
REQ-028 Set DIV = 64:
- bright = 0 -> an = F on every cycle;
- bright = 8 -> an is low on at most 8 of any 16 consecutive cycles;
- bright = 15 -> an is low on all non-dead cycles.
REQ-029 Assert rst for 1 cycle mid-slot while idx = 2 -> outputs SHALL follow REQ-022/023 and scanning SHALL resume at idx 0 with zeroed shadow.
